// File: rtl/mc_core_pkg.sv
// Shared definitions for the mc_core multi-cycle processor: opcodes,
// sequencer states and instruction field positions.
package mc_core_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // Least-significant bit of each field inside the 16-bit instruction word.
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core: ADD/SUB produce carry (SUB carry = borrow),
// logical ops clear carry; zero flags an all-zero truncated result.
module mc_alu
    import mc_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] ext;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (which would infer a latch).
    always_comb begin
        ext   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                carry = ext[DATA_W];
            end
            OP_SUB: begin
                ext   = {1'b0, a} - {1'b0, b};
                carry = ext[DATA_W];
            end
            OP_AND:  ext = {1'b0, a & b};
            OP_OR:   ext = {1'b0, a | b};
            OP_XOR:  ext = {1'b0, a ^ b};
            default: ext = '0;
        endcase
        result = ext[DATA_W-1:0];
        zero   = (result == '0);
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 16-bit-instruction processor with writable program memory,
// on-chip data memory and an 8-entry register file, sequenced IDLE/FETCH/EXEC/WB.
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IMEM_AW = 4,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic [2:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic [IMEM_AW-1:0] pc,
    output logic [15:0]        ir,
    output logic               busy,
    output logic               halted,
    output logic               carry,
    output logic               zero,
    output logic               retire
);

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               halted_q, halted_d;
    logic [DATA_W-1:0]  rf_q [8];
    logic [DATA_W-1:0]  dmem_rdata_q;

    logic [15:0]        imem_q [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem_q [2**DMEM_AW];

    logic [3:0]         opcode;
    logic [2:0]         rd_idx, rs1_idx, rs2_idx;
    logic [7:0]         imm;
    logic [DMEM_AW-1:0] dmem_addr;

    logic               rf_we;
    logic [DATA_W-1:0]  rf_wdata;
    logic               dmem_we, dmem_re;
    logic               retire_c;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry, alu_zero;

    assign opcode    = ir_q[OPC_LSB +: 4];
    assign rd_idx    = ir_q[RD_LSB  +: 3];
    assign rs1_idx   = ir_q[RS1_LSB +: 3];
    assign rs2_idx   = ir_q[RS2_LSB +: 3];
    assign imm       = ir_q[IMM_LSB +: 8];
    assign dmem_addr = imm[DMEM_AW-1:0];

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (rf_q[rs1_idx]),
        .b      (rf_q[rs2_idx]),
        .op     (opcode),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        dmem_we  = 1'b0;
        dmem_re  = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = imem_q[pc_q];
                pc_d    = pc_q + IMEM_AW'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                retire_c = 1'b1;
                state_d  = ST_FETCH;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_result;
                        carry_d  = alu_carry;
                        zero_d   = alu_zero;
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = DATA_W'(imm);
                    end
                    OP_LD: begin
                        // Read data arrives one cycle later; retire happens in WB.
                        dmem_re  = 1'b1;
                        retire_c = 1'b0;
                        state_d  = ST_WB;
                    end
                    OP_ST:   dmem_we = 1'b1;
                    OP_JMP:  pc_d = imm[IMEM_AW-1:0];
                    OP_JZ:   if (zero_q)  pc_d = imm[IMEM_AW-1:0];
                    OP_JC:   if (carry_q) pc_d = imm[IMEM_AW-1:0];
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_wdata = dmem_rdata_q;
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values, which makes rd==rs1/rs2 read-before-write for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
            if (rf_we) rf_q[rd_idx] <= rf_wdata;
        end
    end

    // NOTE: the memories carry no reset so they map onto RAM; the program
    // therefore survives reset and data memory keeps its contents.
    always_ff @(posedge clk) begin
        if (prog_we && (reset || state_q == ST_IDLE)) imem_q[prog_addr] <= prog_data;
        if (dmem_we && !reset) dmem_q[dmem_addr] <= rf_q[rd_idx];
        if (dmem_re) dmem_rdata_q <= dmem_q[dmem_addr];
    end

    assign dbg_rdata = rf_q[dbg_raddr];
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign busy      = (state_q != ST_IDLE);
    assign halted    = halted_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    // An instruction cut short by reset does not retire.
    assign retire    = retire_c & ~reset;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: stimulus pushes expected retire records
// (instruction, flags afterwards) into a queue that a monitor checks.
module tb_mc_core;

    logic        clk = 1'b0;
    logic        reset, start, prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [2:0]  dbg_raddr;
    logic [7:0]  dbg_rdata;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        busy, halted, carry, zero, retire;

    logic        w_start, w_prog_we;
    logic [2:0]  w_prog_addr, w_pc;
    logic [15:0] w_prog_data, w_ir;
    logic [2:0]  w_dbg_raddr;
    logic [7:0]  w_dbg_rdata;
    logic        w_busy, w_halted, w_carry, w_zero, w_retire;

    always #5 clk = ~clk;

    mc_core dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .pc(pc), .ir(ir), .busy(busy), .halted(halted),
        .carry(carry), .zero(zero), .retire(retire)
    );

    mc_core #(.DATA_W(8), .IMEM_AW(3), .DMEM_AW(8)) dut_wrap (
        .clk(clk), .reset(reset), .start(w_start), .prog_we(w_prog_we),
        .prog_addr(w_prog_addr), .prog_data(w_prog_data), .dbg_raddr(w_dbg_raddr),
        .dbg_rdata(w_dbg_rdata), .pc(w_pc), .ir(w_ir), .busy(w_busy), .halted(w_halted),
        .carry(w_carry), .zero(w_zero), .retire(w_retire)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic        c;
        logic        z;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] prog[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_retire = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] r_op(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] i_op(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic p(input logic [15:0] w);
        prog.push_back(w);
    endtask

    task automatic expect_retire(input int idx, input logic c, input logic z);
        exp_q.push_back('{ir: prog[idx], c: c, z: z});
    endtask

    // Monitor: every retire pops one record; flags are compared on the
    // following cycle, once the instruction's flag update has committed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                n_retire++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL retire: unexpected retire of ir=%h, none expected", ir);
                end else begin
                    e = exp_q.pop_front();
                    check("retire ir", 32'(ir), 32'(e.ir));
                    @(negedge clk);
                    check("carry after retire", 32'(carry), 32'(e.c));
                    check("zero after retire", 32'(zero), 32'(e.z));
                end
            end
        end
    end

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] v);
        dbg_raddr = idx;
        #1 v = dbg_rdata;
    endtask

    task automatic check_reg(input string name, input logic [2:0] idx, input logic [7:0] exp);
        logic [7:0] v;
        read_reg(idx, v);
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_main();
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = prog[i];
        end
        @(negedge clk) prog_we = 1'b0;
    endtask

    // Pulses start, then counts edges until halted. disturb_at injects a
    // start plus a program write while busy; abort_at asserts reset there.
    task automatic run_prog(input int disturb_at, input int abort_at, output int cycles);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy after start", 32'(busy), 32'd1);
        cycles = 0;
        forever begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == disturb_at) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'h7000;
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            if (cycles == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                break;
            end
            if (halted === 1'b1) break;
            if (cycles >= 400) begin
                n_cmp++;
                n_fail++;
                $display("FAIL run timeout: got no halt, expected halt within 400 cycles");
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_prog_a(input string tag, input int cycles);
        check({tag, " halt cycles"}, 32'(cycles), 32'd13);
        check({tag, " halted"}, 32'(halted), 32'd1);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        check_reg({tag, " r7"}, 3'd7, 8'h09);
        check_reg({tag, " r5"}, 3'd5, 8'h09);
    endtask

    initial begin
        int cycles;
        int base;
        logic busy_ok;
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        dbg_raddr = '0;
        w_start = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0; w_dbg_raddr = '0;

        // Program A, loaded while reset is held high.
        p(i_op(4'h8, 3'd0, 8'h07)); p(i_op(4'h8, 3'd1, 8'h02)); p(r_op(4'h0, 3'd7, 3'd0, 3'd1));
        p(i_op(4'hA, 3'd7, 8'hFF)); p(i_op(4'h9, 3'd5, 8'hFF)); p(16'hF000);
        repeat (2) @(posedge clk);
        load_main();
        @(negedge clk) reset = 1'b0;
        #1;
        check("reset pc", 32'(pc), 32'd0);
        check("reset ir", 32'(ir), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset carry", 32'(carry), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        check("reset retire", 32'(retire), 32'd0);
        for (int i = 0; i < 8; i++) check_reg("reset reg", 3'(i), 8'h00);

        for (int i = 0; i < 6; i++) expect_retire(i, 1'b0, 1'b0);
        run_prog(0, 0, cycles);
        check_prog_a("clean", cycles);

        // Same program with start and a program write attempted mid-run.
        for (int i = 0; i < 6; i++) expect_retire(i, 1'b0, 1'b0);
        run_prog(3, 0, cycles);
        check_prog_a("busy-ignore", cycles);

        // Reset during the WB cycle of LD (after edge 10), then re-run.
        for (int i = 0; i < 4; i++) expect_retire(i, 1'b0, 1'b0);
        run_prog(0, 10, cycles);
        check("wb-reset busy", 32'(busy), 32'd0);
        check("wb-reset pc", 32'(pc), 32'd0);
        check("wb-reset ir", 32'(ir), 32'd0);
        check("wb-reset halted", 32'(halted), 32'd0);
        check_reg("wb-reset r5", 3'd5, 8'h00);
        check_reg("wb-reset r7", 3'd7, 8'h00);
        for (int i = 0; i < 6; i++) expect_retire(i, 1'b0, 1'b0);
        run_prog(0, 0, cycles);
        check_prog_a("rerun", cycles);

        // Program B: flags, JC taken/not taken, XOR, OR with rd==rs1.
        do_reset();
        prog.delete();
        p(i_op(4'h8, 3'd0, 8'hFF)); p(i_op(4'h8, 3'd1, 8'h01)); p(r_op(4'h0, 3'd2, 3'd0, 3'd1));
        p(i_op(4'h8, 3'd3, 8'h02)); p(r_op(4'h1, 3'd4, 3'd1, 3'd3)); p(i_op(4'hE, 3'd0, 8'h07));
        p(16'hF000);                p(r_op(4'h2, 3'd5, 3'd0, 3'd1)); p(r_op(4'h4, 3'd6, 3'd0, 3'd3));
        p(i_op(4'hE, 3'd0, 8'h06)); p(r_op(4'h3, 3'd6, 3'd6, 3'd1)); p(16'hF000);
        load_main();
        expect_retire(0, 0, 0); expect_retire(1, 0, 0); expect_retire(2, 1, 1);
        expect_retire(3, 1, 1); expect_retire(4, 1, 0); expect_retire(5, 1, 0);
        expect_retire(7, 0, 0); expect_retire(8, 0, 0); expect_retire(9, 0, 0);
        expect_retire(10, 0, 0); expect_retire(11, 0, 0);
        run_prog(0, 0, cycles);
        check("flags halted", 32'(halted), 32'd1);
        check_reg("flags add r2", 3'd2, 8'h00);
        check_reg("flags sub r4", 3'd4, 8'hFF);
        check_reg("flags and r5", 3'd5, 8'h01);
        check_reg("flags xor/or r6", 3'd6, 8'hFD);

        // Program C: countdown loop.
        do_reset();
        prog.delete();
        p(i_op(4'h8, 3'd0, 8'h03)); p(i_op(4'h8, 3'd1, 8'h01)); p(r_op(4'h1, 3'd0, 3'd0, 3'd1));
        p(i_op(4'hD, 3'd0, 8'h05)); p(i_op(4'hC, 3'd0, 8'h02)); p(16'hF000);
        load_main();
        expect_retire(0, 0, 0); expect_retire(1, 0, 0);
        expect_retire(2, 0, 0); expect_retire(3, 0, 0); expect_retire(4, 0, 0);
        expect_retire(2, 0, 0); expect_retire(3, 0, 0); expect_retire(4, 0, 0);
        expect_retire(2, 0, 1); expect_retire(3, 0, 1); expect_retire(5, 0, 1);
        base = n_retire;
        run_prog(0, 0, cycles);
        check("loop retire count", 32'(n_retire - base), 32'd11);
        check("loop halted", 32'(halted), 32'd1);
        check_reg("loop r0", 3'd0, 8'h00);

        // Wrap: 8-entry program memory full of NOPs, no HALT.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w_prog_we = 1'b1; w_prog_addr = 3'(i); w_prog_data = 16'h7000;
        end
        @(negedge clk) w_prog_we = 1'b0;
        @(negedge clk) w_start = 1'b1;
        @(posedge clk);
        #1 w_start = 1'b0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (w_busy !== 1'b1) busy_ok = 1'b0;
            check("wrap pc", 32'(w_pc), 32'(((k + 1) / 2) % 8));
        end
        check("wrap busy held", 32'(busy_ok), 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
